// File: rtl/seg7_scan_driver_if.sv
// ============================================================================
// Module   : seg7_scan_driver_if
// Brief    : Display data request and segment/digit-enable bundle for
//            seg7_scan_driver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seg7_scan_driver_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] data;
    logic [DIGITS-1:0]   dp;
    logic [7:0]          led;
    logic [DIGITS-1:0]   sa;

    modport master (
        output data,
        output dp,
        input  led,
        input  sa
    );

    modport slave (
        input  data,
        input  dp,
        output led,
        output sa
    );
endinterface

`default_nettype wire

// File: rtl/seg7_scan_driver.sv
// ============================================================================
// Module   : seg7_scan_driver
// Brief    : Time-multiplexed N-digit common-anode 7-segment driver with hex
//            decode, per-digit decimal point, dead time and frame-wide capture.
//            Optional leading-zero blanking with SEG7_LZ_BLANK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_scan_driver #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 100000,
    parameter int DEAD     = 2
) (
    input  wire               clk,
    input  wire               rst_n,
    seg7_scan_driver_if.slave bus
);

    localparam int c_idx_w = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int c_pre_w = $clog2(SCAN_DIV);

    localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(SCAN_DIV - 1);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(DIGITS - 1);

    logic [c_pre_w-1:0]  r_pre;
    logic [c_idx_w-1:0]  r_idx;
    logic [4*DIGITS-1:0] r_shadow_data;
    logic [DIGITS-1:0]   r_shadow_dp;
    logic [7:0]          r_led;
    logic [DIGITS-1:0]   r_sa;

    logic                w_pre_last;
    logic                w_frame;
    logic                w_dead;
    logic [3:0]          w_nib;
    logic                w_dp_bit;
    logic                w_blank_bit;
    logic [DIGITS-1:0]   w_blank;
    logic [DIGITS-1:0]   w_sa_next;

    function automatic logic [6:0] f_hex7(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001101;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0000100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

    assign w_pre_last = (r_pre == c_pre_last);
    assign w_frame    = w_pre_last && (r_idx == c_idx_last);

    generate
        if (DEAD == 0) begin : g_no_dead
            assign w_dead = 1'b0;
        end else begin : g_dead
            assign w_dead = (r_pre < c_pre_w'(DEAD));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= '0;
            r_idx <= '0;
        end else if (w_pre_last) begin
            r_pre <= '0;
            r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    // Inputs are sampled only on the frame boundary so a frame is never torn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow_data <= '0;
            r_shadow_dp   <= '0;
        end else if (w_frame) begin
            r_shadow_data <= bus.data;
            r_shadow_dp   <= bus.dp;
        end
    end

`ifdef SEG7_LZ_BLANK_EN
    logic w_zero_above;

    // Walk from the most significant digit down; digit 0 always shows.
    always_comb begin
        w_zero_above = 1'b1;
        w_blank      = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_zero_above = w_zero_above & (r_shadow_data[4*i +: 4] == 4'h0);
            if (i > 0) begin
                w_blank[i] = w_zero_above;
            end
        end
    end
`else
    assign w_blank = '0;
`endif

    always_comb begin
        w_nib       = '0;
        w_dp_bit    = 1'b0;
        w_blank_bit = 1'b0;
        w_sa_next   = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == c_idx_w'(i)) begin
                w_nib       = r_shadow_data[4*i +: 4];
                w_dp_bit    = r_shadow_dp[i];
                w_blank_bit = w_blank[i];
                if (!w_dead) begin
                    w_sa_next[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led <= 8'hFF;
            r_sa  <= '1;
        end else begin
            r_led <= {(w_blank_bit ? 7'h7F : f_hex7(w_nib)), ~w_dp_bit};
            r_sa  <= w_sa_next;
        end
    end

    assign bus.led = r_led;
    assign bus.sa  = r_sa;

endmodule

`default_nettype wire
